// File: rtl/uart_rx_framer.sv
// UART receive framer: 2-FF synchroniser, 3-sample majority vote, configurable data/stop bits,
// frame/parity error pulses and a valid/ready output with sticky overrun. Parity: UART_RX_PARITY_EN.
module uart_rx_framer #(
  parameter int SYS_FREQ_HZ   = 12_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int NUM_DATA_BITS = 8,
  parameter int NUM_STOP_BITS = 1,
  parameter int PARITY_ODD    = 0
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     rx_in,
  output logic [NUM_DATA_BITS-1:0] data_out,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic                     frame_err,
  output logic                     parity_err,
  output logic                     overrun,
  output logic                     busy
);

  localparam int CLKS_PER_BIT = SYS_FREQ_HZ / BAUD_RATE;
  localparam int MID          = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_DATA = 4'(NUM_DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(NUM_STOP_BITS - 1);

  if (NUM_DATA_BITS < 5 || NUM_DATA_BITS > 9 ||
      (NUM_STOP_BITS != 1 && NUM_STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1) || CLKS_PER_BIT < 4) begin : g_param_check
    $error("uart_rx_framer: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE
  } state_t;

  state_t                   state_q, state_d;
  logic                     rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0]               samp_q, samp_d;
  logic [CNT_W-1:0]         clk_cnt_q, clk_cnt_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
  logic                     stop_err_q, stop_err_d;
  logic [NUM_DATA_BITS-1:0] data_out_q, data_out_d;
  logic                     data_valid_q, data_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overrun_q, overrun_d;
  logic                     vote, at_vote, at_end;

`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic par_err_q, par_err_d;
  logic parity_err_q, parity_err_d;
`endif

  assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign at_vote = (clk_cnt_q == CNT_VOTE);
  assign at_end  = (clk_cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    samp_d       = samp_q;
    clk_cnt_d    = at_end ? '0 : clk_cnt_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    stop_err_d   = stop_err_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q & ~data_ready;
    frame_err_d  = 1'b0;
    overrun_d    = overrun_q;
`ifdef UART_RX_PARITY_EN
    par_err_d    = par_err_q;
    parity_err_d = 1'b0;
`endif

    if (clk_cnt_q == CNT_S0) samp_d[0] = rx_s_q;
    if (clk_cnt_q == CNT_S1) samp_d[1] = rx_s_q;

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (rx_prev_q && !rx_s_q) begin
          state_d    = START;
          stop_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          par_err_d  = 1'b0;
`endif
        end
      end
      START: begin
        // A high vote means the falling edge was noise: drop back silently.
        if (at_vote && vote) begin
          state_d   = IDLE;
          clk_cnt_d = '0;
        end else if (at_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_vote) shift_d = {vote, shift_q[NUM_DATA_BITS-1:1]};
        if (at_end) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_vote) par_err_d = vote ^ (^shift_q) ^ ODD;
        if (at_end) state_d = STOP;
      end
`endif
      STOP: begin
        // The last stop bit ends the frame at its vote point, not its end.
        if (at_vote) begin
          if (!vote) stop_err_d = 1'b1;
          if (bit_cnt_q == LAST_STOP) state_d = DONE;
        end
        if (at_end) bit_cnt_d = bit_cnt_q + 4'd1;
      end
      DONE: begin
        state_d     = IDLE;
        clk_cnt_d   = '0;
        frame_err_d = stop_err_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d = par_err_q;
`endif
        if (!stop_err_q) begin
          if (data_valid_q && !data_ready) overrun_d = 1'b1;
          data_out_d   = shift_q;
          data_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      samp_q       <= 2'b11;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      stop_err_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_in;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      samp_q       <= samp_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      stop_err_q   <= stop_err_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= par_err_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: random and directed frames, expected words queued by a frame-level
// model and checked by an independent monitor at the consumer handshake.
`timescale 1ns/1ps
module tb_uart_rx_framer;

  localparam int CPB = 12_000_000 / 115_200;
`ifdef UART_RX_PARITY_EN
  localparam int NSTOP = 2;
  localparam bit PAR   = 1'b1;
`else
  localparam int NSTOP = 1;
  localparam bit PAR   = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       data_ready = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_err, parity_err, overrun, busy;

  uart_rx_framer #(
    .SYS_FREQ_HZ(12_000_000), .BAUD_RATE(115_200), .NUM_DATA_BITS(8),
    .NUM_STOP_BITS(NSTOP), .PARITY_ODD(0)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_in(rx_in), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  always #41.667 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t hold[$];
  int   checks = 0, failures = 0;
  int   exp_ferr = 0, got_ferr = 0, exp_perr = 0, got_perr = 0;
  logic exp_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Line-level frame: start, 8 data LSB first, optional parity, stop bit(s); one inverted cycle optional.
  task automatic send_frame(input logic [7:0] d, input bit pflip, input bit s1_low,
                            input bit s2_low, input int gl_bit, input int gl_off);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (PAR) q.push_back((^d) ^ pflip);
    q.push_back(!s1_low);
    if (NSTOP == 2) q.push_back(!s2_low);
    for (int b = 0; b < q.size(); b++)
      for (int c = 0; c < CPB; c++) begin
        rx_in = (b == gl_bit && c == gl_off) ? ~q[b] : q[b];
        tick();
      end
    rx_in = 1'b1;
  endtask

  // Frame-level model: a good frame fills the one-word holding register, replacing an unconsumed
  // word (and raising overrun) when the consumer is stalled.
  task automatic frame(input logic [7:0] d, input bit pflip, input bit s1_low,
                       input bit s2_low, input int gl_bit, input int gl_off);
    exp_t e;
    if (pflip) exp_perr++;
    if (s1_low || s2_low) begin
      exp_ferr++;
    end else begin
      if (!data_ready && hold.size() > 0) begin
        void'(hold.pop_back());
        exp_ovr = 1'b1;
      end
      e.data = d;
      e.perr = pflip;
      hold.push_back(e);
    end
    send_frame(d, pflip, s1_low, s2_low, gl_bit, gl_off);
    tick(3);
    check("ferr_count", 32'(got_ferr), 32'(exp_ferr));
    check("perr_count", 32'(got_perr), 32'(exp_perr));
    check("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 32'h0);
    check({tag, "_data_valid"}, 32'(data_valid), 32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_parity_err"}, 32'(parity_err), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Monitor
  logic prev_valid = 1'b0, prev_hs = 1'b0, prev_ferr = 1'b0;
  always @(negedge sys_clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      prev_ferr  = 1'b0;
    end else begin
      if (frame_err) begin
        got_ferr++;
        check("ferr_pulse_width", 32'(prev_ferr), 32'h0);
      end
      if (parity_err) got_perr++;
      if (prev_hs) check("valid_clear", 32'(data_valid), 32'h0);
      if (data_valid && !prev_valid) check("busy_at_valid", 32'(busy), 32'h0);
      if (data_valid && data_ready) begin
        if (hold.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%0h required=no word", data_out);
        end else begin
          e = hold.pop_front();
          check("data_out", 32'(data_out), 32'(e.data));
          if (!prev_valid) check("parity_err_with_word", 32'(parity_err), 32'(e.perr));
        end
      end
      prev_hs    = data_valid && data_ready;
      prev_valid = data_valid;
      prev_ferr  = frame_err;
    end
  end

  initial begin
    logic [7:0] d;
    int gl, off;
    bit bad, pf;

    rst_n = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(5);

    // Good frame with a ready consumer
    frame(8'hCA, 0, 0, 0, -1, 0);
    check("idle_after_frame", 32'(busy), 32'h0);

    // Back-to-back frames into a stalled consumer
    data_ready = 1'b0;
    frame(8'h9B, 0, 0, 0, -1, 0);
    frame(8'h38, 0, 0, 0, -1, 0);
    check("stall_valid", 32'(data_valid), 32'h1);
    check("stall_data", 32'(data_out), 32'h38);
    tick(5);
    data_ready = 1'b1;
    tick(3);
    check("stall_drain", 32'(hold.size()), 32'h0);

    // Stop bit low, then a clean frame
    frame(8'hE5, 0, 1, 0, -1, 0);
    frame(8'h90, 0, 0, 0, -1, 0);

    // Sub-cycle glitch straddling a clock edge
    @(posedge sys_clk);
    #70 rx_in = 1'b0;
    #30 rx_in = 1'b1;
    tick(100);
    check("glitch30_busy", 32'(busy), 32'h0);
    check("glitch30_valid", 32'(data_valid), 32'h0);
    check("glitch30_ferr", 32'(got_ferr), 32'(exp_ferr));

    // 40-clock low pulse: enters START, rejected at the vote
    rx_in = 1'b0;
    tick(10);
    check("glitch40_start", 32'(busy), 32'h1);
    tick(30);
    rx_in = 1'b1;
    tick(50);
    check("glitch40_busy", 32'(busy), 32'h0);
    check("glitch40_valid", 32'(data_valid), 32'h0);
    check("glitch40_ferr", 32'(got_ferr), 32'(exp_ferr));

    // One-cycle inversion at mid-bit inside a data bit
    frame(8'hB2, 0, 0, 0, 4, CPB / 2);

`ifdef UART_RX_PARITY_EN
    frame(8'h97, 0, 0, 0, -1, 0);
    frame(8'h97, 1, 0, 0, -1, 0);
    frame(8'h97, 0, 0, 1, -1, 0);
`endif

    // Reset during data bit 4 of 0xF4, then a clean frame
    data_ready = 1'b0;
    frame(8'h61, 0, 0, 0, -1, 0);
    data_ready = 1'b1;
    tick(3);
    fork
      send_frame(8'hF4, 0, 0, 0, -1, 0);
      begin
        tick(CPB * 5 + 50);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_ovr = 1'b0;
        check_all_zero("midreset");
      end
    join
    tick(3);
    check("midreset_ferr", 32'(got_ferr), 32'(exp_ferr));
    frame(8'h25, 0, 0, 0, -1, 0);

    // Break: line held low for many frame times
    exp_ferr++;
    rx_in = 1'b0;
    tick(CPB * 14 * NSTOP);
    check("break_ferr", 32'(got_ferr), 32'(exp_ferr));
    check("break_idle", 32'(busy), 32'h0);
    check("break_valid", 32'(data_valid), 32'h0);
    rx_in = 1'b1;
    tick(CPB);
    frame(8'h5A, 0, 0, 0, -1, 0);

    // Random frames
    for (int n = 0; n < 12; n++) begin
      d   = 8'($urandom_range(0, 255));
      gl  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1;
      off = int'($urandom_range(0, CPB - 1));
      bad = ($urandom_range(0, 5) == 0);
      pf  = PAR && ($urandom_range(0, 1) == 1);
      frame(d, pf, bad, 0, gl, off);
      tick(int'($urandom_range(0, 40)));
    end

    for (int i = 0; i < 2000 && hold.size() > 0; i++) tick();
    check("final_drain", 32'(hold.size()), 32'h0);
    check("final_ferr", 32'(got_ferr), 32'(exp_ferr));
    check("final_perr", 32'(got_perr), 32'(exp_perr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
